udp_tx_word_unpacker: RTL

- Read-side consumer of the 32-bit show-ahead UDP TX buffer FIFO, which is filled by the FDMA DDR read path.
- Waits until one full packet payload is buffered, then requests a UDP transmit with the payload length.
- Once the stack grants, serialises the FIFO words MSB-byte-first onto an 8-bit valid/ready stream for the UDP/MAC TX engine.
- Runs entirely in the FIFO read-clock domain.

---
 rtl/udp_tx_word_unpacker.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/udp_tx_word_unpacker.sv
`default_nettype none
// ============================================================================
//  Module   : udp_tx_word_unpacker
//  Purpose  : Drains one packet of 32-bit words from a show-ahead FIFO and
//             streams them MSB-byte-first to the UDP TX engine.
//  Revision : 1.0  initial release
// ============================================================================
module udp_tx_word_unpacker #(
    parameter int PKT_WORDS   = 256,
    parameter int USEDW_WIDTH = 12,
    parameter int IFG_CYCLES  = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [31:0]            fifo_dout,
    input  logic                   fifo_empty,
    input  logic [USEDW_WIDTH-1:0] fifo_rdusedw,
    output logic                   fifo_re,
    output logic                   tx_req,
    output logic [15:0]            tx_len,
    input  logic                   tx_ack,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   tx_last,
    output logic                   pkt_done,
    output logic [15:0]            pkt_cnt,
    output logic                   underrun
);

    localparam int c_WL_W  = $clog2(PKT_WORDS + 1);
    localparam int c_GAP_W = $clog2(IFG_CYCLES + 1);
    localparam logic [c_WL_W-1:0]  c_PKT_WORDS = c_WL_W'(PKT_WORDS);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST  = c_GAP_W'(IFG_CYCLES - 1);
    localparam logic [31:0]        c_THRESH    = 32'(PKT_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SEND = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_tx_req;
    logic [c_WL_W-1:0]   r_words_left;
    logic [31:0]         r_shreg;
    logic [1:0]          r_idx;
    logic                r_tx_valid;
    logic                r_tx_last;
    logic                r_pkt_done;
    logic [15:0]         r_pkt_cnt;
    logic                r_underrun;
    logic [c_GAP_W-1:0]  r_gap_cnt;

    logic                w_thresh;
    logic                w_accept;
    logic                w_final_byte;
    logic                w_need_load;
    logic                w_load;
    logic                w_pkt_end;
    logic                w_req_set;
    logic                w_ack_take;

    // Zero-extend both sides so any USEDW_WIDTH / PKT_WORDS pairing compares correctly.
    assign w_thresh     = 32'(fifo_rdusedw) >= c_THRESH;
    assign w_accept     = r_tx_valid & tx_ready;
    assign w_final_byte = w_accept & (r_idx == 2'd3);
    assign w_pkt_end    = w_final_byte & (r_words_left == '0);

    // A new word is fetched when the buffer is idle or its last byte leaves now,
    // which keeps consecutive words gap-free on the byte stream.
    assign w_need_load  = (r_state == S_SEND) && (r_words_left != '0) &&
                          (!r_tx_valid || w_final_byte);
    assign w_load       = w_need_load & ~fifo_empty;

    always_comb begin
        w_state_nxt = r_state;
        w_req_set   = 1'b0;
        w_ack_take  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en && w_thresh) begin
                    w_state_nxt = S_REQ;
                    w_req_set   = 1'b1;
                end
            end
            S_REQ: begin
                if (tx_ack) begin
                    w_state_nxt = S_SEND;
                    w_ack_take  = 1'b1;
                end
            end
            S_SEND: begin
                if (w_pkt_end) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tx_req     <= 1'b0;
            r_words_left <= '0;
            r_shreg      <= '0;
            r_idx        <= '0;
            r_tx_valid   <= 1'b0;
            r_tx_last    <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_pkt_cnt    <= '0;
            r_underrun   <= 1'b0;
            r_gap_cnt    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pkt_done <= w_pkt_end;

            if (w_req_set) begin
                r_tx_req <= 1'b1;
            end else if (w_ack_take) begin
                r_tx_req <= 1'b0;
            end

            if (w_ack_take) begin
                r_words_left <= c_PKT_WORDS;
                r_idx        <= '0;
                r_tx_valid   <= 1'b0;
                r_tx_last    <= 1'b0;
            end else if (w_pkt_end) begin
                r_tx_valid <= 1'b0;
                r_tx_last  <= 1'b0;
                r_pkt_cnt  <= r_pkt_cnt + 16'd1;
            end else if (w_load) begin
                r_shreg      <= fifo_dout;
                r_idx        <= '0;
                r_words_left <= r_words_left - c_WL_W'(1);
                r_tx_valid   <= 1'b1;
                r_tx_last    <= 1'b0;
            end else if (w_accept) begin
                r_shreg   <= {r_shreg[23:0], 8'h00};
                r_idx     <= r_idx + 2'd1;
                r_tx_last <= (r_idx == 2'd2) && (r_words_left == '0);
                // Final byte gone with no replacement word: stall without inventing data.
                if (r_idx == 2'd3) begin
                    r_tx_valid <= 1'b0;
                end
            end

            if (w_need_load && fifo_empty) begin
                r_underrun <= 1'b1;
            end

            if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    assign fifo_re  = w_load;
    assign tx_req   = r_tx_req;
    assign tx_len   = 16'(PKT_WORDS * 4);
    assign tx_data  = r_shreg[31:24];
    assign tx_valid = r_tx_valid;
    assign tx_last  = r_tx_last;
    assign pkt_done = r_pkt_done;
    assign pkt_cnt  = r_pkt_cnt;
    assign underrun = r_underrun;

endmodule
`default_nettype wire
